// File: rtl/fwd_hazard_unit_if.sv
// D-stage operand bundle for the forwarding/hazard unit.
// The master drives the decoded D instruction; the slave returns selects and stall.
interface fwd_hazard_unit_if #(
  parameter int NSRC = 2,
  parameter int AW   = 5,
  parameter int SELW = 2
);
  logic                   iIssue_Valid;
  logic [NSRC*AW-1:0]     iRsrc_RegD;
  logic [NSRC-1:0]        iRsrc_Use;
  logic [AW-1:0]          iWsel_RegD;
  logic                   iRegWrite_RegD;
  logic                   iIsLoad_RegD;
  logic                   iFlush;
  logic [NSRC*SELW-1:0]   oFU_Sel;
  logic                   oStall;
  logic [15:0]            oStallCnt;

  modport master (
    output iIssue_Valid, iRsrc_RegD, iRsrc_Use,
    output iWsel_RegD, iRegWrite_RegD, iIsLoad_RegD,
    output iFlush,
    input  oFU_Sel, oStall, oStallCnt
  );

  modport slave (
    input  iIssue_Valid, iRsrc_RegD, iRsrc_Use,
    input  iWsel_RegD, iRegWrite_RegD, iIsLoad_RegD,
    input  iFlush,
    output oFU_Sel, oStall, oStallCnt
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Tracks downstream writers, picks forwarding sources per operand
// and raises load-use stalls while a load result is not yet available.
module fwd_hazard_unit #(
  parameter int NSRC     = 2,
  parameter int DEPTH    = 3,
  parameter int AW       = 5,
  parameter int LOAD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  fwd_hazard_unit_if.slave bus
);
  localparam int SELW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wsel;
    logic          regWrite;
    logic          isLoad;
  } entry_t;

  entry_t ent [1:DEPTH];
  entry_t dEnt;

  logic [NSRC*SELW-1:0] sel;
  logic [NSRC-1:0]      stallReq;
  logic                 stall;
  logic [15:0]          stallCnt;

  assign dEnt = {1'b1, bus.iWsel_RegD,
                 bus.iRegWrite_RegD, bus.iIsLoad_RegD};

  // Walk oldest to youngest so the youngest match overrides.
  always_comb begin
    sel      = '0;
    stallReq = '0;
    for (int i = 0; i < NSRC; i++) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (ent[k].valid && ent[k].regWrite &&
            (ent[k].wsel != '0) &&
            (ent[k].wsel == bus.iRsrc_RegD[i*AW +: AW]) &&
            bus.iRsrc_Use[i]) begin
          if (ent[k].isLoad && (k <= LOAD_LAT)) begin
            sel[i*SELW +: SELW] = '0;
            stallReq[i]         = 1'b1;
          end else begin
            sel[i*SELW +: SELW] = SELW'(k);
            stallReq[i]         = 1'b0;
          end
        end
      end
    end
  end

  assign stall = ~rst & (|stallReq) &
                 bus.iIssue_Valid & ~bus.iFlush;

  assign bus.oFU_Sel   = rst ? '0 : sel;
  assign bus.oStall    = stall;
  assign bus.oStallCnt = stallCnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= DEPTH; k++) ent[k] <= '0;
      stallCnt <= '0;
    end else begin
      if (bus.iIssue_Valid && !stall && !bus.iFlush)
        ent[1] <= dEnt;
      else
        ent[1] <= '0;
      // The flushed instruction was in entry 1, so entry 2 is squashed too.
      for (int k = 2; k <= DEPTH; k++) begin
        if (k == 2 && bus.iFlush) ent[k] <= '0;
        else                      ent[k] <= ent[k-1];
      end
      if (stall && stallCnt != 16'hFFFF)
        stallCnt <= stallCnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: per-cycle reference model plus directed literals.
// A second deep instance drives the stall counter into saturation.
module tb_fwd_hazard_unit;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int D1 = 3;
  localparam int L1 = 1;
  localparam int S1 = $clog2(D1 + 1);
  localparam int D2 = 7;
  localparam int L2 = 6;
  localparam int S2 = $clog2(D2 + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fwd_hazard_unit_if #(.NSRC(NS), .AW(AW), .SELW(S1)) b1 ();
  fwd_hazard_unit_if #(.NSRC(NS), .AW(AW), .SELW(S2)) b2 ();

  fwd_hazard_unit #(.NSRC(NS), .DEPTH(D1), .AW(AW), .LOAD_LAT(L1))
    dut1 (.clk(clk), .rst(rst), .bus(b1));
  fwd_hazard_unit #(.NSRC(NS), .DEPTH(D2), .AW(AW), .LOAD_LAT(L2))
    dut2 (.clk(clk), .rst(rst), .bus(b2));

  int nTests = 0;
  int nFail  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: a list of in-flight instructions per unit.
  typedef struct {
    bit v;
    int w;
    bit rw;
    bit ld;
  } ent_t;

  ent_t m [2][8];
  int   mCnt [2];
  int   dep [2];
  int   lat [2];

  bit   sIv [2];
  bit   sFl [2];
  bit   sRw [2];
  bit   sLd [2];
  int   sWs [2];
  int   sRs [2][2];
  bit   sUs [2][2];
  int   eSel [2][2];
  bit   eSt [2];

  task automatic snap();
    sIv[0] = b1.iIssue_Valid;
    sFl[0] = b1.iFlush;
    sRw[0] = b1.iRegWrite_RegD;
    sLd[0] = b1.iIsLoad_RegD;
    sWs[0] = int'(b1.iWsel_RegD);
    sIv[1] = b2.iIssue_Valid;
    sFl[1] = b2.iFlush;
    sRw[1] = b2.iRegWrite_RegD;
    sLd[1] = b2.iIsLoad_RegD;
    sWs[1] = int'(b2.iWsel_RegD);
    for (int i = 0; i < 2; i++) begin
      sRs[0][i] = int'(b1.iRsrc_RegD[i*AW +: AW]);
      sRs[1][i] = int'(b2.iRsrc_RegD[i*AW +: AW]);
      sUs[0][i] = b1.iRsrc_Use[i];
      sUs[1][i] = b2.iRsrc_Use[i];
    end
  endtask

  task automatic modelEval(input int u);
    bit anyReq;
    anyReq = 0;
    for (int i = 0; i < 2; i++) begin
      eSel[u][i] = 0;
      for (int k = 1; k <= dep[u]; k++) begin
        if (m[u][k].v && m[u][k].rw && m[u][k].w != 0 &&
            m[u][k].w == sRs[u][i] && sUs[u][i]) begin
          if (m[u][k].ld && k <= lat[u]) anyReq = 1;
          else eSel[u][i] = k;
          break;
        end
      end
    end
    eSt[u] = anyReq && sIv[u] && !sFl[u];
    if (rst) begin
      eSel[u][0] = 0;
      eSel[u][1] = 0;
      eSt[u] = 0;
    end
  endtask

  task automatic modelClear(input int u);
    for (int k = 0; k < 8; k++) m[u][k] = '{0, 0, 0, 0};
    mCnt[u] = 0;
  endtask

  task automatic modelStep(input int u);
    for (int k = dep[u]; k >= 2; k--) m[u][k] = m[u][k-1];
    if (sFl[u]) m[u][2] = '{0, 0, 0, 0};
    if (sIv[u] && !eSt[u] && !sFl[u])
      m[u][1] = '{1, sWs[u], sRw[u], sLd[u]};
    else
      m[u][1] = '{0, 0, 0, 0};
    if (eSt[u] && mCnt[u] < 65535) mCnt[u]++;
  endtask

  initial begin
    dep[0] = D1; lat[0] = L1;
    dep[1] = D2; lat[1] = L2;
    modelClear(0);
    modelClear(1);
  end

  // One compare per negedge: check, then advance the model.
  always @(negedge clk) begin
    logic [31:0] a;
    snap();
    for (int u = 0; u < 2; u++) begin
      if (rst) modelClear(u);
      modelEval(u);
      for (int i = 0; i < 2; i++) begin
        a = (u == 0) ? 32'(b1.oFU_Sel[i*S1 +: S1])
                     : 32'(b2.oFU_Sel[i*S2 +: S2]);
        chk($sformatf("u%0d sel%0d @%0t", u, i, $time),
            a, eSel[u][i]);
      end
      a = (u == 0) ? 32'(b1.oStall) : 32'(b2.oStall);
      chk($sformatf("u%0d stall @%0t", u, $time), a, eSt[u]);
      a = (u == 0) ? 32'(b1.oStallCnt) : 32'(b2.oStallCnt);
      chk($sformatf("u%0d cnt @%0t", u, $time), a, mCnt[u]);
      if (!rst) modelStep(u);
    end
  end

  task automatic setD(input int u, input bit v,
                      input int r0, input int r1,
                      input bit [1:0] useMask,
                      input int ws, input bit rw,
                      input bit ld, input bit fl);
    if (u == 0) begin
      b1.iIssue_Valid   = v;
      b1.iRsrc_RegD     = {5'(r1), 5'(r0)};
      b1.iRsrc_Use      = useMask;
      b1.iWsel_RegD     = 5'(ws);
      b1.iRegWrite_RegD = rw;
      b1.iIsLoad_RegD   = ld;
      b1.iFlush         = fl;
    end else begin
      b2.iIssue_Valid   = v;
      b2.iRsrc_RegD     = {5'(r1), 5'(r0)};
      b2.iRsrc_Use      = useMask;
      b2.iWsel_RegD     = 5'(ws);
      b2.iRegWrite_RegD = rw;
      b2.iIsLoad_RegD   = ld;
      b2.iFlush         = fl;
    end
  endtask

  task automatic go(input bit v, input int r0, input int r1,
                    input bit [1:0] useMask, input int ws,
                    input bit rw, input bit ld, input bit fl);
    @(posedge clk);
    #1;
    setD(0, v, r0, r1, useMask, ws, rw, ld, fl);
    #1;
  endtask

  function automatic int sel1(input int i);
    return int'(b1.oFU_Sel[i*S1 +: S1]);
  endfunction

  initial begin
    bit found;
    setD(0, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    setD(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #2;
    chk("rst stall", b1.oStall, 0);
    chk("rst sel", b1.oFU_Sel, 0);
    chk("rst cnt", b1.oStallCnt, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // ALU write r3 then walk it down the pipe
    go(1, 0, 0, 2'b00, 3, 1, 0, 0);
    go(0, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu e1", sel1(0), 1);
    chk("alu e1 stall", b1.oStall, 0);
    go(0, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu e2", sel1(0), 2);
    go(0, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu e3", sel1(0), 3);
    go(0, 3, 0, 2'b01, 0, 0, 0, 0);
    chk("alu gone", sel1(0), 0);

    // load-use on src1
    go(1, 0, 0, 2'b00, 5, 1, 1, 0);
    go(1, 0, 5, 2'b10, 6, 1, 0, 0);
    chk("ldu stall", b1.oStall, 1);
    chk("ldu sel1", sel1(1), 0);
    chk("ldu cnt0", b1.oStallCnt, 0);
    go(1, 0, 5, 2'b10, 6, 1, 0, 0);
    chk("ldu released", b1.oStall, 0);
    chk("ldu fwd e2", sel1(1), 2);
    chk("ldu cnt1", b1.oStallCnt, 1);
    go(0, 0, 0, 2'b00, 0, 0, 0, 0);

    // two writers of r7: youngest wins on both sources
    go(1, 0, 0, 2'b00, 7, 1, 0, 0);
    go(1, 0, 0, 2'b00, 7, 1, 0, 0);
    go(0, 7, 7, 2'b11, 0, 0, 0, 0);
    chk("youngest s0", sel1(0), 1);
    chk("youngest s1", sel1(1), 1);

    // r0 never matches; unused source never matches
    go(1, 0, 0, 2'b00, 0, 1, 1, 0);
    go(1, 0, 7, 2'b01, 0, 1, 0, 0);
    chk("r0 sel", sel1(0), 0);
    chk("unused sel", sel1(1), 0);
    chk("r0 stall", b1.oStall, 0);

    // flush kills the stall and both young entries
    go(1, 0, 0, 2'b00, 5, 1, 1, 0);
    go(1, 5, 0, 2'b01, 8, 1, 0, 1);
    chk("flush stall", b1.oStall, 0);
    chk("flush sel", sel1(0), 0);
    go(0, 5, 0, 2'b01, 0, 0, 0, 0);
    chk("post flush sel", sel1(0), 0);
    chk("post flush cnt", b1.oStallCnt, 1);
    go(0, 5, 0, 2'b01, 0, 0, 0, 0);
    chk("post flush e3", sel1(0), 0);

    // younger load shadows older ALU
    go(1, 0, 0, 2'b00, 9, 1, 0, 0);
    go(1, 0, 0, 2'b00, 9, 1, 1, 0);
    go(1, 9, 0, 2'b01, 4, 1, 0, 0);
    chk("ld over alu stall", b1.oStall, 1);
    go(1, 9, 0, 2'b01, 4, 1, 0, 0);
    chk("ld over alu e2", sel1(0), 2);
    chk("ld over alu cnt", b1.oStallCnt, 2);

    // younger ALU shadows older load
    go(1, 0, 0, 2'b00, 10, 1, 1, 0);
    go(1, 0, 0, 2'b00, 10, 1, 0, 0);
    go(1, 10, 0, 2'b01, 0, 0, 0, 0);
    chk("alu over ld sel", sel1(0), 1);
    chk("alu over ld stall", b1.oStall, 0);
    repeat (4) go(0, 0, 0, 2'b00, 0, 0, 0, 0);

    // deep unit: self-dependent load stalls 6 of every 7 cycles
    @(posedge clk);
    #1;
    setD(1, 1, 5, 0, 2'b01, 5, 1, 1, 0);
    repeat (76600) @(posedge clk);
    #2;
    chk("cnt saturated", b2.oStallCnt, 16'hFFFF);
    found = 0;
    for (int n = 0; n < 10 && !found; n++) begin
      if (b2.oStall) found = 1;
      else begin
        @(posedge clk);
        #2;
      end
    end
    chk("stall seen", found, 1);
    rst = 1'b1;
    #1;
    chk("async rst cnt", b2.oStallCnt, 0);
    chk("async rst stall", b2.oStall, 0);
    chk("async rst sel", b2.oFU_Sel, 0);
    chk("async rst sel u0", b1.oFU_Sel, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    setD(1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("post rst cnt", b2.oStallCnt, 0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
